// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard detection inputs and pipeline-register controls of the hazard controller
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic             idex_mem_read_i;
  logic [4:0]       idex_rd_i;
  logic [4:0]       ifid_rs1_i;
  logic [4:0]       ifid_rs2_i;
  logic             ifid_uses_rs1_i;
  logic             ifid_uses_rs2_i;
  logic             exmem_branch_taken_i;
  logic             dmem_req_i;
  logic             dmem_ack_i;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_write_o;
  logic             idex_bubble_o;
  logic             exmem_write_o;
  logic             exmem_bubble_o;
  logic             memwb_bubble_o;
  logic             mem_err_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  logic             state_o;
  modport master (
    output idex_mem_read_i, idex_rd_i, ifid_rs1_i, ifid_rs2_i, ifid_uses_rs1_i, ifid_uses_rs2_i,
           exmem_branch_taken_i, dmem_req_i, dmem_ack_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_bubble_o, exmem_write_o,
           exmem_bubble_o, memwb_bubble_o, mem_err_o, stall_cnt_o, flush_cnt_o, state_o
  );
  modport slave (
    input  idex_mem_read_i, idex_rd_i, ifid_rs1_i, ifid_rs2_i, ifid_uses_rs1_i, ifid_uses_rs2_i,
           exmem_branch_taken_i, dmem_req_i, dmem_ack_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_bubble_o, exmem_write_o,
           exmem_bubble_o, memwb_bubble_o, mem_err_o, stall_cnt_o, flush_cnt_o, state_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush controller for load-use, taken-branch and multi-cycle memory hazards
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input logic                   clk_i,
  input logic                   rst_i,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int WW = $clog2(MEM_TIMEOUT) + 1;
  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;
  state_t           state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic             err_q, err_d;
  logic             stall_inc, flush_inc, load_use, mem_stall;
  assign load_use = bus.idex_mem_read_i && (bus.idex_rd_i != 5'd0) &&
                    ((bus.ifid_uses_rs1_i && bus.ifid_rs1_i == bus.idex_rd_i) ||
                     (bus.ifid_uses_rs2_i && bus.ifid_rs2_i == bus.idex_rd_i));
  assign mem_stall = bus.dmem_req_i && !bus.dmem_ack_i;
  always_comb begin
    bus.pc_write_o     = 1'b1;
    bus.ifid_write_o   = 1'b1;
    bus.ifid_flush_o   = 1'b0;
    bus.idex_write_o   = 1'b1;
    bus.idex_bubble_o  = 1'b0;
    bus.exmem_write_o  = 1'b1;
    bus.exmem_bubble_o = 1'b0;
    bus.memwb_bubble_o = 1'b0;
    state_d            = state_q;
    wait_d             = wait_q;
    err_d              = err_q;
    stall_inc          = 1'b0;
    flush_inc          = 1'b0;
    if (state_q == RUN) begin
      if (mem_stall) begin
        {bus.pc_write_o, bus.ifid_write_o, bus.idex_write_o, bus.exmem_write_o} = 4'b0000;
        bus.memwb_bubble_o = 1'b1;
        state_d            = MEM_WAIT;
        wait_d             = WW'(1);
        stall_inc          = 1'b1;
      end else if (bus.exmem_branch_taken_i) begin
        bus.ifid_flush_o   = 1'b1;
        bus.idex_bubble_o  = 1'b1;
        bus.exmem_bubble_o = 1'b1;
        flush_inc          = 1'b1;
      end else if (load_use) begin
        bus.pc_write_o    = 1'b0;
        bus.ifid_write_o  = 1'b0;
        bus.idex_bubble_o = 1'b1;
        stall_inc         = 1'b1;
      end
    end else if (bus.dmem_ack_i) begin
      state_d = RUN;
    end else if (wait_q < WW'(MEM_TIMEOUT - 1)) begin
      {bus.pc_write_o, bus.ifid_write_o, bus.idex_write_o, bus.exmem_write_o} = 4'b0000;
      bus.memwb_bubble_o = 1'b1;
      wait_d             = wait_q + WW'(1);
      stall_inc          = 1'b1;
    end else begin
      // timeout: let the pipe move on but drop the never-delivered load result
      bus.memwb_bubble_o = 1'b1;
      err_d              = 1'b1;
      state_d            = RUN;
    end
    if (rst_i) begin
      {bus.pc_write_o, bus.ifid_write_o, bus.idex_write_o, bus.exmem_write_o} = 4'b0000;
      bus.ifid_flush_o   = 1'b1;
      bus.idex_bubble_o  = 1'b1;
      bus.exmem_bubble_o = 1'b1;
      bus.memwb_bubble_o = 1'b1;
    end
    stall_d = (stall_inc && stall_q != '1) ? stall_q + CNT_W'(1) : stall_q;
    flush_d = (flush_inc && flush_q != '1) ? flush_q + CNT_W'(1) : flush_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      err_q   <= err_d;
    end
  end
  assign bus.mem_err_o   = err_q;
  assign bus.stall_cnt_o = stall_q;
  assign bus.flush_cnt_o = flush_q;
  assign bus.state_o     = state_q;
endmodule
